// File: rtl/rv32_hazard_pkg.sv
// rv32_hazard_pkg: shared types and constants for the scoreboard hazard unit
package rv32_hazard_pkg;
  typedef enum logic {IDLE, DRAIN} fence_state_t;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/rv32_scoreboard_regs.sv
// rv32_scoreboard_regs: pending-load bits and outstanding-load counter with same-cycle bypass lookups
module rv32_scoreboard_regs
  import rv32_hazard_pkg::*;
#(
  parameter int REG_BITS = 5,
  parameter int MAX_OUTSTANDING = 2,
  localparam int NUM_REGS = 2 ** REG_BITS,
  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                accept_i,
  input  logic                set_i,
  input  logic [REG_BITS-1:0] set_rd_i,
  input  logic                resp_i,
  input  logic [REG_BITS-1:0] resp_rd_i,
  input  logic [REG_BITS-1:0] rs1_i,
  input  logic [REG_BITS-1:0] rs2_i,
  input  logic [REG_BITS-1:0] rd_i,
  output logic                rs1_busy_o,
  output logic                rs2_busy_o,
  output logic                rd_busy_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [CNT_BITS-1:0] count_o
);
  logic [NUM_REGS-1:0] pending_q, pending_d, set_mask, clr_mask;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic inc, dec;
  // x0 is never marked; set wins over a same-cycle clear; counter ignores a response with nothing in flight
  always_comb begin
    set_mask = (accept_i && set_i && set_rd_i != REG_BITS'(REG_ZERO)) ? NUM_REGS'(1) << set_rd_i : '0;
    clr_mask = resp_i ? NUM_REGS'(1) << resp_rd_i : '0;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    dec = resp_i && count_q != '0;
    inc = accept_i && (count_q != CNT_BITS'(MAX_OUTSTANDING) || dec);
    count_d = (inc && !dec) ? count_q + CNT_BITS'(1) : (!inc && dec) ? count_q - CNT_BITS'(1) : count_q;
  end
  // scoreboard state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      count_q <= '0;
    end else begin
      pending_q <= pending_d;
      count_q <= count_d;
    end
  end
  // a register whose load returns this cycle is already available
  always_comb begin
    rs1_busy_o = pending_q[rs1_i] && !(resp_i && resp_rd_i == rs1_i);
    rs2_busy_o = pending_q[rs2_i] && !(resp_i && resp_rd_i == rs2_i);
    rd_busy_o = pending_q[rd_i] && !(resp_i && resp_rd_i == rd_i);
  end
  assign pending_o = pending_q;
  assign count_o = count_q;
endmodule

// File: rtl/rv32_scoreboard_hazard.sv
// rv32_scoreboard_hazard: load scoreboard, fence drain FSM and pipeline stall/flush chain
module rv32_scoreboard_hazard
  import rv32_hazard_pkg::*;
#(
  parameter int REG_BITS = 5,
  parameter int MAX_OUTSTANDING = 2,
  localparam int NUM_REGS = 2 ** REG_BITS,
  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] decode_rs1_unreg_in,
  input  logic [REG_BITS-1:0] decode_rs2_unreg_in,
  input  logic                decode_rs1_read_unreg_in,
  input  logic                decode_rs2_read_unreg_in,
  input  logic [REG_BITS-1:0] decode_rd_unreg_in,
  input  logic                decode_rd_write_unreg_in,
  input  logic                decode_mem_fence_unreg_in,
  input  logic [REG_BITS-1:0] execute_rd_in,
  input  logic                execute_rd_write_in,
  input  logic                execute_mem_fence_in,
  input  logic                mem_branch_mispredicted_in,
  input  logic                instr_read_in,
  input  logic                instr_ready_in,
  input  logic                data_read_in,
  input  logic                data_write_in,
  input  logic                data_ready_in,
  input  logic                data_resp_valid_in,
  input  logic [REG_BITS-1:0] data_resp_rd_in,
  output logic                fetch_stall_out,
  output logic                decode_stall_out,
  output logic                decode_flush_out,
  output logic                execute_stall_out,
  output logic                execute_flush_out,
  output logic                mem_stall_out,
  output logic                mem_flush_out,
  output logic                writeback_flush_out,
  output logic [NUM_REGS-1:0] pending_out,
  output logic [CNT_BITS-1:0] outstanding_out
);
  fence_state_t state_q, state_d;
  logic rs1_busy, rs2_busy, rd_busy, raw, waw, slot_full, fetch_wait, execute_wait, fence_wait;

  rv32_scoreboard_regs #(.REG_BITS(REG_BITS), .MAX_OUTSTANDING(MAX_OUTSTANDING)) u_regs (
    .clk(clk),
    .reset(reset),
    .accept_i(data_read_in && data_ready_in),
    .set_i(execute_rd_write_in),
    .set_rd_i(execute_rd_in),
    .resp_i(data_resp_valid_in),
    .resp_rd_i(data_resp_rd_in),
    .rs1_i(decode_rs1_unreg_in),
    .rs2_i(decode_rs2_unreg_in),
    .rd_i(decode_rd_unreg_in),
    .rs1_busy_o(rs1_busy),
    .rs2_busy_o(rs2_busy),
    .rd_busy_o(rd_busy),
    .pending_o(pending_out),
    .count_o(outstanding_out)
  );

  // fence state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // a fence leaving execute waits in DRAIN until every load has returned and no store is on the bus
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = (execute_mem_fence_in && !execute_stall_out && !mem_branch_mispredicted_in) ? DRAIN : IDLE;
    else state_d = (outstanding_out == '0 && !data_write_in) ? IDLE : DRAIN;
  end
  // stall/flush priority chain, purely combinational
  always_comb begin
    raw = (decode_rs1_read_unreg_in && rs1_busy) || (decode_rs2_read_unreg_in && rs2_busy);
    waw = decode_rd_write_unreg_in && decode_rd_unreg_in != REG_BITS'(REG_ZERO) && rd_busy;
    slot_full = data_read_in && outstanding_out == CNT_BITS'(MAX_OUTSTANDING) && !data_resp_valid_in;
    fetch_wait = instr_read_in && !instr_ready_in;
    execute_wait = (data_read_in || data_write_in) && !data_ready_in;
    fence_wait = decode_mem_fence_unreg_in || execute_mem_fence_in || state_q == DRAIN;
    mem_stall_out = 1'b0;
    execute_stall_out = mem_stall_out || execute_wait || slot_full;
    decode_stall_out = execute_stall_out;
    fetch_stall_out = decode_stall_out || raw || waw || fetch_wait || fence_wait;
    decode_flush_out = fetch_stall_out || mem_branch_mispredicted_in;
    execute_flush_out = decode_stall_out || mem_branch_mispredicted_in;
    mem_flush_out = execute_stall_out;
    writeback_flush_out = mem_stall_out;
  end
endmodule

// File: tb/tb_rv32_scoreboard_hazard.sv
// tb_rv32_scoreboard_hazard: directed self-checking bench for the scoreboard hazard unit
module tb_rv32_scoreboard_hazard;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] decode_rs1_unreg_in, decode_rs2_unreg_in, decode_rd_unreg_in, execute_rd_in, data_resp_rd_in;
  logic decode_rs1_read_unreg_in, decode_rs2_read_unreg_in, decode_rd_write_unreg_in, decode_mem_fence_unreg_in;
  logic execute_rd_write_in, execute_mem_fence_in, mem_branch_mispredicted_in;
  logic instr_read_in, instr_ready_in, data_read_in, data_write_in, data_ready_in, data_resp_valid_in;
  logic fetch_stall_out, decode_stall_out, decode_flush_out, execute_stall_out, execute_flush_out;
  logic mem_stall_out, mem_flush_out, writeback_flush_out;
  logic [31:0] pending_out;
  logic [1:0] outstanding_out;
  logic allow_err;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rv32_scoreboard_hazard dut (
    .clk(clk),
    .reset(reset),
    .decode_rs1_unreg_in(decode_rs1_unreg_in),
    .decode_rs2_unreg_in(decode_rs2_unreg_in),
    .decode_rs1_read_unreg_in(decode_rs1_read_unreg_in),
    .decode_rs2_read_unreg_in(decode_rs2_read_unreg_in),
    .decode_rd_unreg_in(decode_rd_unreg_in),
    .decode_rd_write_unreg_in(decode_rd_write_unreg_in),
    .decode_mem_fence_unreg_in(decode_mem_fence_unreg_in),
    .execute_rd_in(execute_rd_in),
    .execute_rd_write_in(execute_rd_write_in),
    .execute_mem_fence_in(execute_mem_fence_in),
    .mem_branch_mispredicted_in(mem_branch_mispredicted_in),
    .instr_read_in(instr_read_in),
    .instr_ready_in(instr_ready_in),
    .data_read_in(data_read_in),
    .data_write_in(data_write_in),
    .data_ready_in(data_ready_in),
    .data_resp_valid_in(data_resp_valid_in),
    .data_resp_rd_in(data_resp_rd_in),
    .fetch_stall_out(fetch_stall_out),
    .decode_stall_out(decode_stall_out),
    .decode_flush_out(decode_flush_out),
    .execute_stall_out(execute_stall_out),
    .execute_flush_out(execute_flush_out),
    .mem_stall_out(mem_stall_out),
    .mem_flush_out(mem_flush_out),
    .writeback_flush_out(writeback_flush_out),
    .pending_out(pending_out),
    .outstanding_out(outstanding_out)
  );

  // a response with nothing in flight is a protocol violation unless deliberately provoked
  always @(negedge clk)
    if (!reset && !allow_err)
      assert (!(data_resp_valid_in && outstanding_out == 2'd0)) else $error("protocol: response with no outstanding load");

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    decode_rs1_unreg_in = 0; decode_rs2_unreg_in = 0; decode_rd_unreg_in = 0;
    decode_rs1_read_unreg_in = 0; decode_rs2_read_unreg_in = 0; decode_rd_write_unreg_in = 0;
    decode_mem_fence_unreg_in = 0; execute_rd_in = 0; execute_rd_write_in = 0; execute_mem_fence_in = 0;
    mem_branch_mispredicted_in = 0; instr_read_in = 0; instr_ready_in = 0;
    data_read_in = 0; data_write_in = 0; data_ready_in = 0; data_resp_valid_in = 0; data_resp_rd_in = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] rd);
    data_read_in = 1; data_ready_in = 1; execute_rd_write_in = 1; execute_rd_in = rd;
  endtask

  task automatic resp(input logic [4:0] rd);
    data_resp_valid_in = 1; data_resp_rd_in = rd;
  endtask

  initial begin
    reset = 1; allow_err = 0; idle();
    tick();
    check("rst_pending", pending_out, 0);
    check("rst_count", outstanding_out, 0);
    check("rst_fetch_stall", fetch_stall_out, 0);
    check("rst_decode_flush", decode_flush_out, 0);
    reset = 0;
    instr_read_in = 1; #1;
    check("fetch_wait_fstall", fetch_stall_out, 1);
    check("fetch_wait_dstall", decode_stall_out, 0);
    check("fetch_wait_dflush", decode_flush_out, 1);
    idle(); data_write_in = 1; #1;
    check("store_wait_estall", execute_stall_out, 1);
    check("store_wait_mflush", mem_flush_out, 1);
    check("store_wait_wbflush", writeback_flush_out, 0);
    idle(); tick();
    load(5); #1;
    check("ld5_accept_estall", execute_stall_out, 0);
    tick(); idle();
    decode_rs1_read_unreg_in = 1; decode_rs1_unreg_in = 5; #1;
    check("ld5_pending", pending_out, 32'h20);
    check("ld5_raw_c1", fetch_stall_out, 1);
    tick(); #1;
    check("ld5_raw_c2", fetch_stall_out, 1);
    tick(); resp(5); #1;
    check("ld5_bypass", fetch_stall_out, 0);
    check("ld5_pending_resp_cycle", pending_out, 32'h20);
    tick(); idle(); #1;
    check("ld5_cleared", pending_out, 0);
    check("ld5_count", outstanding_out, 0);
    load(0); tick(); idle();
    decode_rs1_read_unreg_in = 1; decode_rs1_unreg_in = 0; #1;
    check("ld0_pending", pending_out, 0);
    check("ld0_count", outstanding_out, 1);
    check("ld0_no_raw", fetch_stall_out, 0);
    resp(0); tick(); idle(); #1;
    check("ld0_drained", outstanding_out, 0);
    load(3); tick(); load(4); tick(); idle();
    load(6); #1;
    check("full_count", outstanding_out, 2);
    check("full_estall", execute_stall_out, 1);
    check("full_mflush", mem_flush_out, 1);
    resp(3); #1;
    check("full_resp_estall", execute_stall_out, 0);
    tick(); idle(); #1;
    check("acc_resp_count", outstanding_out, 2);
    check("acc_resp_pending", pending_out, 32'h50);
    resp(4); tick(); resp(6); tick(); idle(); #1;
    check("full_drained_count", outstanding_out, 0);
    check("full_drained_pending", pending_out, 0);
    load(9); tick(); idle();
    execute_mem_fence_in = 1; mem_branch_mispredicted_in = 1; #1;
    check("fence_mp_fstall", fetch_stall_out, 1);
    tick(); idle(); #1;
    check("fence_mp_no_drain", fetch_stall_out, 0);
    execute_mem_fence_in = 1; tick(); idle(); #1;
    check("drain_c1", fetch_stall_out, 1);
    tick(); #1;
    check("drain_c2", fetch_stall_out, 1);
    resp(9); #1;
    check("drain_resp_cycle", fetch_stall_out, 1);
    tick(); idle(); tick(); #1;
    check("drain_exit_fstall", fetch_stall_out, 0);
    check("drain_exit_count", outstanding_out, 0);
    load(7); tick(); idle();
    mem_branch_mispredicted_in = 1; #1;
    check("mp_dflush", decode_flush_out, 1);
    check("mp_eflush", execute_flush_out, 1);
    check("mp_fstall", fetch_stall_out, 0);
    tick(); idle(); #1;
    check("mp_pending_kept", pending_out, 32'h80);
    decode_rd_write_unreg_in = 1; decode_rd_unreg_in = 7; #1;
    check("waw_stall", fetch_stall_out, 1);
    resp(7); #1;
    check("waw_bypass", fetch_stall_out, 0);
    tick(); idle(); #1;
    check("mp_resp_cleared", pending_out, 0);
    load(10); tick(); load(11); tick(); idle();
    execute_mem_fence_in = 1; tick(); idle(); #1;
    check("pre_rst_count", outstanding_out, 2);
    check("pre_rst_drain", fetch_stall_out, 1);
    #1 reset = 1; #1;
    check("async_rst_pending", pending_out, 0);
    check("async_rst_count", outstanding_out, 0);
    check("async_rst_fstall", fetch_stall_out, 0);
    tick(); reset = 0; #1;
    check("post_rst_fstall", fetch_stall_out, 0);
    allow_err = 1; resp(3); tick(); idle(); allow_err = 0; #1;
    check("proto_err_count", outstanding_out, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
